// File: rtl/cdf_pkg.sv
// Shared definitions for the multi-region CDF stage: geometry helpers, FSM encoding
// and the per-region word-address helper.
package cdf_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    function automatic int unsigned laneCount(input int unsigned busW, input int unsigned laneW);
        return busW / laneW;
    endfunction

    function automatic int unsigned wordsPerRegion(input int unsigned numBins,
                                                   input int unsigned laneW,
                                                   input int unsigned busW);
        return (numBins * laneW) / busW;
    endfunction

    function automatic int unsigned regionBase(input int unsigned base,
                                               input int unsigned region,
                                               input int unsigned stride);
        return base + region * stride;
    endfunction

endpackage

// File: rtl/cdf_prefix_lane.sv
// Combinational in-word prefix adder: carry-in plus running lane sums, overflow flag and
// first non-zero lane index. Defining CDF_SATURATE_EN clamps sums at the lane maximum.
module cdf_prefix_lane #(
    parameter int unsigned LANE_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANE_W-1:0]       carry,
    input  logic [LANES*LANE_W-1:0] lanes,
    output logic [LANES*LANE_W-1:0] prefix_c,
    output logic [LANE_W-1:0]       accNext_c,
    output logic                    ovf_c,
    output logic                    nzFound_c,
    output logic [IDX_W-1:0]        nzIdx_c
);

    logic [LANE_W:0]   sum;
    logic [LANE_W-1:0] run;

    // One extra bit per addition exposes the carry out of the lane width.
    always_comb begin
        run       = carry;
        sum       = '0;
        ovf_c     = 1'b0;
        nzFound_c = 1'b0;
        nzIdx_c   = '0;
        prefix_c  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum   = {1'b0, run} + {1'b0, lanes[i*LANE_W +: LANE_W]};
            run   = sum[LANE_W-1:0];
`ifdef CDF_SATURATE_EN
            if (sum[LANE_W]) begin
                run = '1;
            end
`endif
            ovf_c = ovf_c | sum[LANE_W];
            prefix_c[i*LANE_W +: LANE_W] = run;
            if (!nzFound_c && (run != '0)) begin
                nzFound_c = 1'b1;
                nzIdx_c   = IDX_W'(i);
            end
        end
        accNext_c = run;
    end

endmodule

// File: rtl/cdf_pipeline_multi.sv
// Multi-region histogram-to-CDF stage: issues histogram reads, aligns returning data to the
// SRAM read latency and writes packed CDF words. Optional macro: CDF_SATURATE_EN.
module cdf_pipeline_multi
    import cdf_pkg::*;
#(
    parameter int unsigned BUS_W         = 128,
    parameter int unsigned LANE_W        = 32,
    parameter int unsigned NUM_BINS      = 256,
    parameter int unsigned NUM_REGIONS   = 2,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned RD_BASE       = 0,
    parameter int unsigned WR_BASE       = 0,
    parameter int unsigned REGION_STRIDE = 64,
    parameter int unsigned READ_LAT      = 1,
    parameter int unsigned SEL_W         = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  region_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [BUS_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BUS_W-1:0]  wr_data,
    output logic [LANE_W-1:0] cdf_min,
    output logic [LANE_W-1:0] cdf_total,
    output logic              cdf_valid,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LANES = laneCount(BUS_W, LANE_W);
    localparam int unsigned WPR   = wordsPerRegion(NUM_BINS, LANE_W, BUS_W);
    localparam int unsigned CNT_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPR - 1);

    logic [1:0]        state;
    logic [1:0]        stateNext;
    logic              accept;
    logic              startPrev;
    logic              startRise;
    logic [SEL_W-1:0]  regionEff;
    logic [SEL_W-1:0]  regionQ;
    logic [CNT_W-1:0]  issueCnt;
    logic [READ_LAT-1:0] vldPipe;
    logic [CNT_W-1:0]  idxPipe [READ_LAT];
    logic              capture;
    logic [CNT_W-1:0]  capIdx;
    logic [LANE_W-1:0] acc;
    logic              minFound;
    logic              wrLast;
    logic              lastWritten;

    logic [BUS_W-1:0]  prefix_c;
    logic [LANE_W-1:0] accNext_c;
    logic              ovf_c;
    logic              nzFound_c;
    logic [IDX_W-1:0]  nzIdx_c;

    assign startRise = start & ~startPrev;
    assign regionEff = (32'(region_sel) < NUM_REGIONS) ? region_sel : '0;
    assign capture   = vldPipe[READ_LAT-1];
    assign capIdx    = idxPipe[READ_LAT-1];

    cdf_prefix_lane #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .IDX_W  (IDX_W)
    ) uPrefix (
        .carry     (acc),
        .lanes     (rd_data),
        .prefix_c  (prefix_c),
        .accNext_c (accNext_c),
        .ovf_c     (ovf_c),
        .nzFound_c (nzFound_c),
        .nzIdx_c   (nzIdx_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (startRise) begin
                    accept    = 1'b1;
                    stateNext = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issueCnt == LAST_WORD) begin
                    stateNext = ST_DRAIN;
                end
            end
            // Leave only once the last write has been on the bus for a full cycle.
            ST_DRAIN: begin
                if (lastWritten) begin
                    stateNext = ST_FIN;
                end
            end
            ST_FIN:  stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            startPrev   <= 1'b0;
            regionQ     <= '0;
            issueCnt    <= '0;
            vldPipe     <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                idxPipe[i] <= '0;
            end
            acc         <= '0;
            minFound    <= 1'b0;
            wrLast      <= 1'b0;
            lastWritten <= 1'b0;
            rd_addr     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cdf_min     <= '0;
            cdf_total   <= '0;
            cdf_valid   <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            startPrev <= start;

            if ((state == ST_ISSUE) && (issueCnt != LAST_WORD)) begin
                issueCnt <= issueCnt + CNT_W'(1);
                rd_addr  <= rd_addr + ADDR_W'(1);
            end

            // Delay line marks the cycle each issued word's data is on rd_data.
            vldPipe[0] <= (state == ST_ISSUE);
            idxPipe[0] <= issueCnt;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                vldPipe[i] <= vldPipe[i-1];
                idxPipe[i] <= idxPipe[i-1];
            end

            wr_en  <= capture;
            wrLast <= capture && (capIdx == LAST_WORD);
            if (capture) begin
                wr_data  <= prefix_c;
                wr_addr  <= ADDR_W'(regionBase(WR_BASE, 32'(regionQ), REGION_STRIDE) + 32'(capIdx));
                acc      <= accNext_c;
                overflow <= overflow | ovf_c;
                if (!minFound && nzFound_c) begin
                    minFound <= 1'b1;
                    cdf_min  <= prefix_c[nzIdx_c*LANE_W +: LANE_W];
                end
            end
            lastWritten <= wr_en & wrLast;

            done <= (state == ST_FIN);
            if (state == ST_FIN) begin
                busy      <= 1'b0;
                cdf_valid <= 1'b1;
                cdf_total <= acc;
            end

            if (accept) begin
                regionQ   <= regionEff;
                issueCnt  <= '0;
                rd_addr   <= ADDR_W'(regionBase(RD_BASE, 32'(regionEff), REGION_STRIDE));
                acc       <= '0;
                minFound  <= 1'b0;
                cdf_min   <= '0;
                overflow  <= 1'b0;
                cdf_valid <= 1'b0;
                busy      <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cdf_pipeline_multi.md
Name: cdf_pipeline_multi

Overview:
- Parametrised successor to the single-image CDF stage.
- Reads a packed histogram from a 2R1W SRAM read port and computes the running cumulative distribution.
- Writes packed CDF words to the output SRAM and reports cdf_min, the first non-zero CDF value, for the equalisation stage.
- Generalises lane width, bin count and region count: the single offset bit becomes a multi-region select, with per-run totals and overflow reporting.

Parameters:
- BUS_W, 128, SRAM data bus width.
- LANE_W, 32, width of one bin count and of one CDF lane; BUS_W % LANE_W == 0.
- NUM_BINS, 256, histogram bins; multiple of BUS_W/LANE_W.
- NUM_REGIONS, 2, independent histogram/CDF regions; >= 1.
- ADDR_W, 16, SRAM address width.
- RD_BASE, 0, word address of region 0 histogram.
- WR_BASE, 0, word address of region 0 CDF output.
- REGION_STRIDE, 64, word distance between regions; >= NUM_BINS*LANE_W/BUS_W.
- READ_LAT, 1, SRAM read latency in cycles (1 or 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; a run begins on its rising edge while idle.
- region_sel  in  max(1,$clog2(NUM_REGIONS))  region; latched when start is accepted.
- rd_addr  out  ADDR_W  histogram read address.
- rd_data  in  BUS_W  histogram word; lane i occupies bits [i*LANE_W +: LANE_W].
- wr_en  out  1  output SRAM write enable.
- wr_addr  out  ADDR_W  output write address.
- wr_data  out  BUS_W  packed CDF word, same lane order as rd_data.
- cdf_min  out  LANE_W  first non-zero CDF value of the last run.
- cdf_total  out  LANE_W  final CDF value (total pixel count).
- cdf_valid  out  1  cdf_min and cdf_total are valid.
- overflow  out  1  accumulation exceeded LANE_W bits during the last run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset values: all outputs 0; state IDLE; start edge detector cleared.
- Definitions: WPR = NUM_BINS*LANE_W/BUS_W words per region; L = BUS_W/LANE_W lanes per word.
- States:
  - IDLE: when a start rising edge is seen, latch region_sel, clear the accumulator, cdf_min, overflow and cdf_valid; set busy; go to ISSUE.
  - ISSUE: rd_addr = RD_BASE + region*REGION_STRIDE + k for k = 0..WPR-1, one per cycle; after the last address go to DRAIN.
  - DRAIN: wait until the final write has been issued, then go to FIN.
  - FIN: done=1, cdf_valid=1, busy=0; go to IDLE.
- Data pipeline: data for address k is sampled READ_LAT cycles after issue. In-word prefix lane j = acc + sum of lanes 0..j; acc is updated to lane L-1. Results are registered, so wr_en for word k asserts READ_LAT+1 cycles after read issue k, with wr_addr = WR_BASE + region*REGION_STRIDE + k. Writes are back-to-back, WPR cycles with wr_en high.
- Latency: accepted start edge to done = WPR + READ_LAT + 3 cycles.
- cdf_min: the first lane, in bin order, whose prefix value is non-zero. If all bins are zero, cdf_min = 0 and cdf_valid still asserts.
- Arithmetic: sums are carried at LANE_W+1 bits internally. overflow is sticky per run. Without the optional feature, values wrap modulo 2^LANE_W.
- Boundaries:
  - start held high across runs does not retrigger; a falling edge is required.
  - start edge while busy: ignored.
  - region_sel >= NUM_REGIONS: treated as region 0.
  - Reset mid-run: immediate IDLE, wr_en=0, no done pulse.
  - cdf_valid, cdf_min, cdf_total and overflow hold until the next accepted start.

Optional Feature:
- Macro CDF_SATURATE_EN.
- Defined: the accumulator and lane values clamp at 2^LANE_W-1 once exceeded, and overflow is set.
- Undefined: wrap-around arithmetic, and overflow is still set.

Decomposition:
- Package cdf_pkg: lane-count and WPR derivation functions, state encoding (IDLE, ISSUE, DRAIN, FIN), region-address helper function.
- Sub-module cdf_prefix_lane: combinational L-lane prefix adder with carry-in acc, optional saturation, and first-non-zero index detect.
- Top level: FSM, address counters, read-latency delay line and output registers.

Test Plan:
- All bins = 1, region 0, default parameters -> 64 writes, word k lanes = 4k+1..4k+4, cdf_min=1, cdf_total=256, done at cycle 68 after the start edge.
- Bins 0..9 = 0, bin 10 = 5, others = 1, region 1 -> first write at WR_BASE+64, cdf_min=5, cdf_total=250.
- All bins zero -> all wr_data 0, cdf_min=0, cdf_valid=1, overflow=0.
- All bins = 0x20000000 -> overflow=1; cdf_total=0 without CDF_SATURATE_EN, 0xFFFFFFFF with it.
- start held high for 2000 cycles -> exactly one run; toggle low then high -> second run, with the latched region honoured.
- Reset asserted at write 20 -> wr_en drops asynchronously, busy=0, no done; a following start completes normally.
